// File: rtl/mem_pkg.sv
// Shared encodings and stage-B payload for the memory access unit.
package mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WADDR_MAX_W = 30;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Request as held between the BRAM read and the response register.
  // The word address is stored at its widest legal width.
  typedef struct packed {
    logic                   we;
    logic [1:0]             size;
    logic                   is_unsigned;
    logic [1:0]             offset;
    logic [WADDR_MAX_W-1:0] waddr;
    logic [WORD_W-1:0]      wdata;
    logic                   err;
  } stage_b_t;

  // Sub-word accesses must be naturally aligned; size 3 is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_H) && offset[0]) ||
           ((size == SIZE_W) && (offset != 2'b00)) ||
           (size == 2'd3);
  endfunction

endpackage

// File: rtl/lane_merge_extract.sv
// Byte/halfword lane insertion for stores and lane extraction for loads.
module lane_merge_extract
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] base,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Replace the addressed lane(s) of base for stores; pick and extend them for loads.
  always_comb begin
    merged    = base;
    load_data = '0;
    byte_sel  = base[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? base[31:16] : base[15:0];
    case (size)
      SIZE_B: begin
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
        load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_H: begin
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SIZE_W: begin
        merged    = wdata;
        load_data = base;
      end
      default: begin
        merged    = base;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a dual-port BRAM: reads on port 0, read-modify-write
// stores on port 1, with last-write forwarding for back-to-back coherence.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic                  ram_en0,
  input  logic [31:0]           ram_rdata0,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  output logic                  ram_en1,
  output logic                  ram_we1,
  output logic [31:0]           ram_wdata1
);

  localparam int unsigned BA_W = ADDR_WIDTH + 2;

  logic                  ready_q;
  logic                  b_valid_q;
  stage_b_t              b_q;
  logic                  lw_valid_q;
  logic [ADDR_WIDTH-1:0] lw_addr_q;
  logic [WORD_W-1:0]     lw_data_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [WORD_W-1:0]     resp_rdata_q;

  logic                  fire;
  logic                  wr_ok;
  logic [WORD_W-1:0]     base;
  logic [WORD_W-1:0]     merged;
  logic [WORD_W-1:0]     load_data;

  // Stage A: issue the port-0 read for every accepted request.
  always_comb begin
    req_ready = rstn & ready_q;
    fire      = req_valid & req_ready;
    ram_en0   = fire;
    ram_addr0 = rstn ? req_addr[BA_W-1:2] : '0;
  end

  // Stage B: pick forwarded data over the BRAM when the last write hit this word.
  always_comb begin
    base = ram_rdata0;
    if (lw_valid_q && (WADDR_MAX_W'(lw_addr_q) == b_q.waddr)) begin
      base = lw_data_q;
    end
  end

  lane_merge_extract u_lane (
    .base        (base),
    .offset      (b_q.offset),
    .size        (b_q.size),
    .is_unsigned (b_q.is_unsigned),
    .wdata       (b_q.wdata),
    .merged      (merged),
    .load_data   (load_data)
  );

  // Stage B: write the merged word back on port 1; suppressed during reset.
  always_comb begin
    wr_ok      = rstn & b_valid_q & b_q.we & ~b_q.err;
    ram_en1    = wr_ok;
    ram_we1    = wr_ok;
    ram_addr1  = wr_ok ? ADDR_WIDTH'(b_q.waddr) : '0;
    ram_wdata1 = wr_ok ? merged : '0;
  end

  // Response outputs are held at zero while reset is asserted.
  always_comb begin
    resp_valid = rstn & resp_valid_q;
    resp_err   = rstn & resp_err_q;
    resp_rdata = rstn ? resp_rdata_q : '0;
  end

  // Pipeline, last-write and response registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_q      <= 1'b0;
      b_valid_q    <= 1'b0;
      b_q          <= '0;
      lw_valid_q   <= 1'b0;
      lw_addr_q    <= '0;
      lw_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      ready_q           <= 1'b1;
      b_valid_q         <= fire;
      b_q.we            <= req_we;
      b_q.size          <= req_size;
      b_q.is_unsigned   <= req_unsigned;
      b_q.offset        <= req_addr[1:0];
      b_q.waddr         <= WADDR_MAX_W'(req_addr[BA_W-1:2]);
      b_q.wdata         <= req_wdata;
      b_q.err           <= is_misaligned(req_size, req_addr[1:0]);
      lw_valid_q        <= ram_we1;
      lw_addr_q         <= ram_addr1;
      lw_data_q         <= ram_wdata1;
      resp_valid_q      <= b_valid_q;
      resp_err_q        <= b_valid_q & b_q.err;
      resp_rdata_q      <= (b_valid_q & ~b_q.we & ~b_q.err) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random checks of mem_access_unit against a behavioural BRAM.
module tb_mem_access_unit;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  ram_addr0;
  logic        ram_en0;
  logic [31:0] ram_rdata0;
  logic [7:0]  ram_addr1;
  logic        ram_en1;
  logic        ram_we1;
  logic [31:0] ram_wdata1;

  int n_vec  = 0;
  int n_miss = 0;
  int we1_cnt = 0;
  logic mem_clear;
  logic [31:0] bram [256];

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  mem_access_unit #(.ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_addr0    (ram_addr0),
    .ram_en0      (ram_en0),
    .ram_rdata0   (ram_rdata0),
    .ram_addr1    (ram_addr1),
    .ram_en1      (ram_en1),
    .ram_we1      (ram_we1),
    .ram_wdata1   (ram_wdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port BRAM; a read colliding with a write to the same word returns garbage.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) bram[i] <= '0;
    end else begin
      if (ram_en1 && ram_we1) bram[ram_addr1] <= ram_wdata1;
      if (ram_en0)
        ram_rdata0 <= (ram_en1 && ram_we1 && ram_addr1 == ram_addr0) ? 32'hBAD0BAD0 : bram[ram_addr0];
    end
  end

  // Count write strobes mid-cycle.
  always @(negedge clk) if (ram_we1) we1_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [9:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    mem_clear = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 10'h3FC, 32'hFFFFFFFF);
    tick; tick; tick;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    n_vec++; if (ram_en0 !== 1'b0) begin n_miss++; $display("FAIL rst_en0: got %b expected 0", ram_en0); end
    n_vec++; if (ram_addr0 !== 8'h00) begin n_miss++; $display("FAIL rst_addr0: got %h expected 00", ram_addr0); end
    n_vec++; if (ram_en1 !== 1'b0 || ram_we1 !== 1'b0) begin n_miss++; $display("FAIL rst_port1: got en=%b we=%b expected 0 0", ram_en1, ram_we1); end
    n_vec++; if (ram_addr1 !== 8'h00 || ram_wdata1 !== 32'h0) begin n_miss++; $display("FAIL rst_port1_data: got %h %h expected 0", ram_addr1, ram_wdata1); end
    n_vec++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_resp: got %b %b %h expected 0", resp_valid, resp_err, resp_rdata); end
    mem_clear = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
    rstn = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL rel_ready_first: got %b expected 0", req_ready); end
    tick;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rel_ready_second: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_store_load;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    tick;
    n_vec++; if (ram_we1 !== 1'b1 || ram_addr1 !== 8'h04 || ram_wdata1 !== 32'hDEADBEEF) begin
      n_miss++; $display("FAIL sw_port1: got we=%b a=%h d=%h expected 1 04 deadbeef", ram_we1, ram_addr1, ram_wdata1); end
    drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_miss++; $display("FAIL sw_resp: got %b %b %h expected 1 0 00000000", resp_valid, resp_err, resp_rdata); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    tick;
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL sw_idle_resp: got %b expected 0", resp_valid); end
    drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
      n_miss++; $display("FAIL lw_resp: got %b %b %h expected 1 0 deadbeef", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_back_to_back;
    logic        we [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'd2, 2'd0, 2'd2};
    logic [9:0]  ad [3] = '{10'h020, 10'h021, 10'h020};
    logic [31:0] wd [3] = '{32'h11223344, 32'h000000AA, 32'h0};
    logic [31:0] ew [3] = '{32'h11223344, 32'h1122AA44, 32'h0};
    logic [31:0] er [3] = '{32'h0, 32'h0, 32'h1122AA44};
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(1'b1, we[i], sz[i], 1'b0, ad[i], wd[i]);
      else       drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
      tick;
      if (i < 3 && we[i]) begin
        n_vec++; if (ram_we1 !== 1'b1 || ram_wdata1 !== ew[i]) begin
          n_miss++; $display("FAIL b2b_wdata[%0d]: got we=%b d=%h expected 1 %h", i, ram_we1, ram_wdata1, ew[i]); end
      end
      if (i > 0) begin
        n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== er[i-1]) begin
          n_miss++; $display("FAIL b2b_resp[%0d]: got %b %b %h expected 1 0 %h", i-1, resp_valid, resp_err, resp_rdata, er[i-1]); end
      end
    end
  endtask

  task automatic test_extension;
    logic        we [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz [5] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        un [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0]  ad [5] = '{10'h030, 10'h031, 10'h032, 10'h032, 10'h030};
    logic [31:0] er [5] = '{32'h0, 32'hFFFFFFFF, 32'h000000F0, 32'hFFFF80F0, 32'h0000FF7F};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) drive(1'b1, we[i], sz[i], un[i], ad[i], 32'h80F0FF7F);
      else       drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
      tick;
      if (i > 0) begin
        n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== er[i-1]) begin
          n_miss++; $display("FAIL ext_resp[%0d]: got %b %b %h expected 1 0 %h", i-1, resp_valid, resp_err, resp_rdata, er[i-1]); end
      end
    end
  endtask

  task automatic test_misaligned;
    logic        we [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd2};
    logic [9:0]  ad [3] = '{10'h033, 10'h002, 10'h030};
    logic        ee [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] er [3] = '{32'h0, 32'h0, 32'h80F0FF7F};
    int snap;
    snap = we1_cnt;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(1'b1, we[i], sz[i], 1'b0, ad[i], 32'h0000BEEF);
      else       drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
      tick;
      if (i > 0) begin
        n_vec++; if (resp_valid !== 1'b1 || resp_err !== ee[i-1] || resp_rdata !== er[i-1]) begin
          n_miss++; $display("FAIL mis_resp[%0d]: got %b %b %h expected 1 %b %h", i-1, resp_valid, resp_err, resp_rdata, ee[i-1], er[i-1]); end
      end
    end
    n_vec++; if (we1_cnt !== snap) begin n_miss++; $display("FAIL mis_no_write: got %0d strobes expected 0", we1_cnt - snap); end
  endtask

  task automatic test_mid_reset;
    int snap;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 10'h040, 32'h01020304);
    tick;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
    tick; tick;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 10'h040, 32'h55555555);
    tick;
    snap = we1_cnt;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
    #1;
    n_vec++; if (ram_we1 !== 1'b0 || ram_en1 !== 1'b0) begin n_miss++; $display("FAIL mrst_we1: got we=%b en=%b expected 0 0", ram_we1, ram_en1); end
    tick;
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL mrst_resp: got %b expected 0", resp_valid); end
    rstn = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL mrst_ready_first: got %b expected 0", req_ready); end
    tick;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_miss++; $display("FAIL mrst_ready_second: got rdy=%b rv=%b expected 1 0", req_ready, resp_valid); end
    n_vec++; if (we1_cnt !== snap) begin n_miss++; $display("FAIL mrst_no_write: got %0d strobes expected 0", we1_cnt - snap); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0);
    tick;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h01020304) begin
      n_miss++; $display("FAIL mrst_mem_kept: got %b %b %h expected 1 0 01020304", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_random;
    logic [7:0] rb [16];
    exp_t q[$];
    exp_t cur;
    int wi, k;
    logic [1:0] off, sz;
    logic we, un, err;
    logic [31:0] wd, d;
    foreach (rb[i]) rb[i] = 8'h00;
    for (int i = 0; i <= 2000; i++) begin
      if (i < 2000) begin
        wi  = int'($urandom_range(3));
        off = 2'($urandom_range(3));
        sz  = 2'($urandom_range(3));
        we  = 1'($urandom_range(1));
        un  = 1'($urandom_range(1));
        wd  = $urandom;
        k   = 4 * wi;
        err = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0) || (sz == 2'd3);
        d   = 32'h0;
        if (!err && we) begin
          if (sz == 2'd0) rb[k + int'(off)] = wd[7:0];
          else if (sz == 2'd1) begin rb[k + int'(off)] = wd[7:0]; rb[k + int'(off) + 1] = wd[15:8]; end
          else begin rb[k] = wd[7:0]; rb[k+1] = wd[15:8]; rb[k+2] = wd[23:16]; rb[k+3] = wd[31:24]; end
        end else if (!err) begin
          if (sz == 2'd0) d = un ? {24'h0, rb[k + int'(off)]} : {{24{rb[k + int'(off)][7]}}, rb[k + int'(off)]};
          else if (sz == 2'd1) d = un ? {16'h0, rb[k + int'(off) + 1], rb[k + int'(off)]}
                                      : {{16{rb[k + int'(off) + 1][7]}}, rb[k + int'(off) + 1], rb[k + int'(off)]};
          else d = {rb[k+3], rb[k+2], rb[k+1], rb[k]};
        end
        drive(1'b1, we, sz, un, {8'(8'h60 + wi), off}, wd);
        q.push_back('{v: 1'b1, e: err, d: d});
      end else begin
        drive(1'b0, 1'b0, 2'd0, 1'b0, 10'h0, 32'h0);
      end
      tick;
      if (i > 0) begin
        cur = q.pop_front();
        n_vec++; if (resp_valid !== cur.v || resp_err !== cur.e || resp_rdata !== cur.d) begin
          n_miss++; $display("FAIL rnd_resp[%0d]: got %b %b %h expected %b %b %h", i-1, resp_valid, resp_err, resp_rdata, cur.v, cur.e, cur.d); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_store_load;
    test_back_to_back;
    test_extension;
    test_misaligned;
    test_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end for the true dual-port data BRAM (32-bit words, no byte enables, 1-cycle registered read).
- Sits between the core's memory stage and the BRAM:
  - port 0 is used for all reads;
  - port 1 is used for all writes.
- Implements byte and halfword stores by read-modify-write, plus sign/zero-extended sub-word loads.
- Forwards the previous cycle's write so that back-to-back accesses to the same word are coherent.

Parameters:
- ADDR_WIDTH, 8, word-address bits of the BRAM. The byte address is ADDR_WIDTH+2 bits.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit accepts a request this cycle
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  misaligned or reserved-size request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- ram_addr0  out  ADDR_WIDTH  port-0 word address
- ram_en0  out  1  port-0 enable
- ram_rdata0  in  32  port-0 read data, valid the cycle after ram_en0
- ram_addr1  out  ADDR_WIDTH  port-1 word address
- ram_en1  out  1  port-1 enable
- ram_we1  out  1  port-1 write enable
- ram_wdata1  out  32  port-1 write data
- Port-0 write enable and write data are tied to 0 at the instantiating level; they are not ports of this block.

Behaviour:
- Reset: while rstn=0, every output is 0. That includes req_ready, resp_*, and all ram_* enables, which are forced 0 combinationally. The pipeline valid bits and the last-write register are cleared at the edge.
- Ready: req_ready is a register set to 1 on the first edge with rstn=1, so it reads 0 during the first cycle after reset release. There is no backpressure afterwards; the consumer always accepts responses.
- Fire: fire = req_valid & req_ready.
- Stage A (cycle T, combinational):
  - ram_en0 = fire; ram_addr0 = req_addr[ADDR_WIDTH+1:2].
  - Port 0 is read for loads and stores alike.
- A→B register: captures valid, we, size, unsigned, byte offset, word address, wdata, and err.
- err = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | size==3.
- Stage B (cycle T+1):
  - base = lw_data if lw_valid & lw_addr==B.addr, else ram_rdata0.
  - Store, no err: merged = base with the selected byte/half/word lanes replaced by the low bits of wdata (lane = offset; half uses offset[1]).
    - Drive ram_en1=1, ram_we1=1, ram_addr1=B.addr, ram_wdata1=merged, combinationally.
  - Load, no err: select lane from base and sign- or zero-extend per unsigned.
  - err: no write; data = 0.
- Last-write register: at every edge, lw_valid <= ram_we1, lw_addr <= ram_addr1, lw_data <= ram_wdata1. Required because a port-0 read in the same cycle as a port-1 write to that address returns undefined data.
- Response register, cycle T+2: resp_valid=1; resp_err=B.err; resp_rdata = extracted load data, or 0 for a store or error.
- Latency: 2 cycles request→response. Throughput: 1 request/cycle.
- Mid-operation reset: in-flight requests are discarded and no write is issued in the reset cycle. BRAM contents already written are not touched.

Decomposition:
- Package mem_pkg:
  - size encoding constants SIZE_B/SIZE_H/SIZE_W;
  - typedef of the stage-B request struct (we, size, unsigned, offset, word address, wdata, err).
- Sub-module lane_merge_extract (combinational): inputs base, offset, size, unsigned, wdata; outputs merged word and extended load value. It is shared by the store and load paths.

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then load word 0x10 two cycles later:
  - store response at T+2 with rdata 0;
  - load resp_rdata 0xDEADBEEF.
- Back-to-back forwarding:
  - Word store 0x20=0x11223344.
  - Next cycle, byte store 0x21 data 0xAA.
  - Next cycle, load word 0x20 → 0x1122AA44.
  - The last write exercises forwarding on each hop.
- Sign/zero extension:
  - Memory word 0x80F0FF7F at 0x30.
  - lb 0x31 → 0xFFFFFFFF; lbu 0x32 → 0x000000F0; lh 0x32 → 0xFFFF80F0; lhu 0x30 → 0x0000FF7F.
- Misaligned:
  - Half store at 0x33 → resp_err=1, ram_we1 never asserted, memory unchanged.
  - Word load 0x02 → resp_err=1, rdata 0.
- Reset handling:
  - Assert rstn=0 in the cycle a store sits in stage B → no ram_we1 pulse, no resp_valid.
  - After release, req_ready=0 for one cycle, then 1.
- Random stream of 2000 mixed requests to 4 word addresses, checked against a byte-array reference model → no data or response mismatch.
